// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: fetch FSM encoding, instruction width,
// PC increment and the default bubble instruction.
package pipe_pkg;

   localparam int              INST_W   = 32;
   localparam logic [31:0]     PC_INCR  = 32'd4;
   localparam logic [31:0]     NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

endpackage : pipe_pkg

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, issues one outstanding
// request to instruction memory, buffers one returned instruction for
// IF/ID and applies branch/jump redirects from ID (dropping wrong-path
// responses and flushing IF/ID).
module if_fetch_stage
   import pipe_pkg::*;
#(
   parameter logic [INST_W-1:0] RESET_PC = 32'h0000_0000,
   parameter logic [INST_W-1:0] NOP_INST = pipe_pkg::NOP_INST
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              IF_ID_Write,
   input  logic              Branch_Taken,
   input  logic [INST_W-1:0] Branch_Target,
   input  logic              Jump,
   input  logic [INST_W-1:0] Jump_Target,
   output logic              imem_req,
   output logic [INST_W-1:0] imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [INST_W-1:0] imem_rdata,
   output logic [INST_W-1:0] Inst_out,
   output logic [INST_W-1:0] PC_out,
   output logic              inst_valid,
   output logic              IF_Flush
);

   fetch_state_t      state_q, state_d;
   logic [INST_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [INST_W-1:0] buf_inst_q, buf_inst_d;
   logic [INST_W-1:0] buf_pc_q, buf_pc_d;
   logic              buf_valid_q, buf_valid_d;
   logic              discard_q, discard_d;
   logic [INST_W-1:0] pend_pc_q, pend_pc_d;
   logic              pend_valid_q, pend_valid_d;

   logic              redirect;
   logic [INST_W-1:0] raw_target;
   logic [INST_W-1:0] target;
   logic              consume;

   // Redirect decode: jump has priority, targets are forced word aligned.
   always_comb begin
      redirect   = Jump | Branch_Taken;
      raw_target = Jump ? Jump_Target : Branch_Target;
      target     = {raw_target[INST_W-1:2], 2'b00};
      consume    = buf_valid_q & IF_ID_Write & ~redirect;
   end

   // State and datapath registers, asynchronously reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         fetch_pc_q   <= RESET_PC;
         buf_inst_q   <= NOP_INST;
         buf_pc_q     <= '0;
         buf_valid_q  <= 1'b0;
         discard_q    <= 1'b0;
         pend_pc_q    <= '0;
         pend_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         fetch_pc_q   <= fetch_pc_d;
         buf_inst_q   <= buf_inst_d;
         buf_pc_q     <= buf_pc_d;
         buf_valid_q  <= buf_valid_d;
         discard_q    <= discard_d;
         pend_pc_q    <= pend_pc_d;
         pend_valid_q <= pend_valid_d;
      end
   end

   // Next-state logic: request handshake, response capture/drop, redirects.
   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      buf_inst_d   = buf_inst_q;
      buf_pc_d     = buf_pc_q;
      buf_valid_d  = buf_valid_q;
      discard_d    = discard_q;
      pend_pc_d    = pend_pc_q;
      pend_valid_d = pend_valid_q;
      imem_req     = 1'b0;

      case (state_q)
         IDLE: begin
            state_d = REQ;
            if (redirect) fetch_pc_d = target;
         end
         REQ: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               // Request is in flight; fetch_pc moves on so that it always
               // sits one word past the outstanding address.
               state_d      = WAIT;
               discard_d    = pend_valid_q | redirect;
               fetch_pc_d   = redirect     ? target    :
                              pend_valid_q ? pend_pc_q :
                                             fetch_pc_q + PC_INCR;
               pend_valid_d = 1'b0;
            end else if (redirect) begin
               // Address must stay stable until accepted, so park the target.
               pend_pc_d    = target;
               pend_valid_d = 1'b1;
            end
         end
         WAIT: begin
            if (redirect) begin
               discard_d  = 1'b1;
               fetch_pc_d = target;
            end
            if (imem_rvalid) begin
               if (discard_q | redirect) begin
                  discard_d = 1'b0;
                  state_d   = REQ;
               end else begin
                  buf_inst_d  = imem_rdata;
                  buf_pc_d    = fetch_pc_q - PC_INCR;
                  buf_valid_d = 1'b1;
                  state_d     = HOLD;
               end
            end
         end
         HOLD: begin
            if (consume) begin
               buf_valid_d = 1'b0;
               state_d     = REQ;
            end else if (redirect) begin
               fetch_pc_d = target;
               state_d    = REQ;
            end
         end
         default: state_d = IDLE;
      endcase

      // A redirect always invalidates whatever instruction is buffered.
      if (redirect) buf_valid_d = 1'b0;
   end

   // IF/ID-facing outputs.
   always_comb begin
      imem_addr  = fetch_pc_q;
      Inst_out   = buf_valid_q ? buf_inst_q : NOP_INST;
      PC_out     = buf_valid_q ? buf_pc_q + PC_INCR : '0;
      inst_valid = buf_valid_q;
      IF_Flush   = redirect;
   end

endmodule : if_fetch_stage

// File: tb/tb_if_fetch_stage.sv
// Directed testbench for if_fetch_stage with a zero-wait memory model.
module tb_if_fetch_stage;

   logic        clk = 1'b0;
   logic        reset, reset2;
   logic        if_id_write, br_taken, jump, mem_ready;
   logic [31:0] br_target, jump_target;

   logic        imem_req, imem_rvalid, inst_valid, if_flush;
   logic [31:0] imem_addr, imem_rdata, inst_out, pc_out;

   logic        imem2_req, imem2_rvalid, inst2_valid, if2_flush;
   logic [31:0] imem2_addr, imem2_rdata, inst2_out, pc2_out;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   if_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk(clk), .reset(reset), .IF_ID_Write(if_id_write),
      .Branch_Taken(br_taken), .Branch_Target(br_target),
      .Jump(jump), .Jump_Target(jump_target),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(mem_ready),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .Inst_out(inst_out), .PC_out(pc_out), .inst_valid(inst_valid),
      .IF_Flush(if_flush)
   );

   if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset2), .IF_ID_Write(1'b1),
      .Branch_Taken(1'b0), .Branch_Target(32'h0),
      .Jump(1'b0), .Jump_Target(32'h0),
      .imem_req(imem2_req), .imem_addr(imem2_addr), .imem_ready(1'b1),
      .imem_rvalid(imem2_rvalid), .imem_rdata(imem2_rdata),
      .Inst_out(inst2_out), .PC_out(pc2_out), .inst_valid(inst2_valid),
      .IF_Flush(if2_flush)
   );

   // Memory contents: address 0 holds 0x2002_0005, others 0xC000_0000|addr.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h0) ? 32'h2002_0005 : (32'hC000_0000 | a);
   endfunction

   // Zero-wait memory: response the cycle after acceptance.
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         imem_rvalid <= 1'b0;
         imem_rdata  <= 32'h0;
      end else begin
         imem_rvalid <= imem_req & mem_ready;
         imem_rdata  <= mem_word(imem_addr);
      end
   end

   always @(posedge clk or posedge reset2) begin
      if (reset2) begin
         imem2_rvalid <= 1'b0;
         imem2_rdata  <= 32'h0;
      end else begin
         imem2_rvalid <= imem2_req;
         imem2_rdata  <= mem_word(imem2_addr);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req"},   {31'd0, imem_req},   32'd0);
      check({tag, "_inst"},  inst_out,            32'h0);
      check({tag, "_pc"},    pc_out,              32'h0);
      check({tag, "_valid"}, {31'd0, inst_valid}, 32'd0);
      check({tag, "_flush"}, {31'd0, if_flush},   32'd0);
   endtask

   initial begin
      reset = 1'b1; reset2 = 1'b1;
      if_id_write = 1'b1; br_taken = 1'b0; jump = 1'b0; mem_ready = 1'b1;
      br_target = 32'h0; jump_target = 32'h0;

      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      reset = 1'b0;

      // First fetch: request at cycle 1, instruction two cycles later.
      @(negedge clk);
      check("req1", {31'd0, imem_req}, 32'd1);
      check("addr1", imem_addr, 32'h0);
      @(negedge clk);
      check("wait1_req", {31'd0, imem_req}, 32'd0);
      check("wait1_valid", {31'd0, inst_valid}, 32'd0);
      @(negedge clk);
      check("hold1_inst", inst_out, 32'h2002_0005);
      check("hold1_pc", pc_out, 32'h4);
      check("hold1_valid", {31'd0, inst_valid}, 32'd1);
      @(negedge clk);
      check("req2_req", {31'd0, imem_req}, 32'd1);
      check("req2_addr", imem_addr, 32'h4);

      // Stall with the buffer full.
      @(negedge clk);
      if_id_write = 1'b0;
      @(negedge clk);
      check("hold2_inst", inst_out, 32'hC000_0004);
      check("hold2_pc", pc_out, 32'h8);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("stall_inst", inst_out, 32'hC000_0004);
         check("stall_pc", pc_out, 32'h8);
         check("stall_req", {31'd0, imem_req}, 32'd0);
      end
      if_id_write = 1'b1;
      @(negedge clk);
      check("req3_req", {31'd0, imem_req}, 32'd1);
      check("req3_addr", imem_addr, 32'h8);

      // Branch during WAIT: response dropped, refetch at target.
      @(negedge clk);
      br_taken = 1'b1; br_target = 32'h40;
      #1 check("br_wait_flush", {31'd0, if_flush}, 32'd1);
      @(negedge clk);
      check("br_wait_valid", {31'd0, inst_valid}, 32'd0);
      check("br_wait_req", {31'd0, imem_req}, 32'd1);
      check("br_wait_addr", imem_addr, 32'h40);
      br_taken = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("hold40_inst", inst_out, 32'hC000_0040);
      check("hold40_pc", pc_out, 32'h44);

      // Redirect in REQ while memory is not ready for two cycles.
      @(negedge clk);
      check("req44_addr", imem_addr, 32'h44);
      mem_ready = 1'b0; br_taken = 1'b1; br_target = 32'h80;
      #1 check("br_req_flush", {31'd0, if_flush}, 32'd1);
      @(negedge clk);
      br_taken = 1'b0;
      check("stuck1_req", {31'd0, imem_req}, 32'd1);
      check("stuck1_addr", imem_addr, 32'h44);
      @(negedge clk);
      check("stuck2_addr", imem_addr, 32'h44);
      mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check("pend_valid", {31'd0, inst_valid}, 32'd0);
      check("pend_req", {31'd0, imem_req}, 32'd1);
      check("pend_addr", imem_addr, 32'h80);
      @(negedge clk);
      @(negedge clk);
      check("hold80_inst", inst_out, 32'hC000_0080);
      check("hold80_pc", pc_out, 32'h84);

      // Jump and branch together in HOLD: jump wins, target aligned.
      jump = 1'b1; jump_target = 32'h103; br_taken = 1'b1; br_target = 32'h80;
      #1 check("jb_flush", {31'd0, if_flush}, 32'd1);
      @(negedge clk);
      jump = 1'b0; br_taken = 1'b0;
      check("jb_valid", {31'd0, inst_valid}, 32'd0);
      check("jb_inst", inst_out, 32'h0);
      check("jb_addr", imem_addr, 32'h100);

      // Asynchronous reset in the middle of WAIT.
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_wait");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("rst_req_addr", imem_addr, 32'h0);
      check("rst_req", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
      @(negedge clk);
      check("rst_hold_valid", {31'd0, inst_valid}, 32'd1);
      // Asynchronous reset with an instruction buffered.
      #2 reset = 1'b1;
      #1 check_reset_outputs("rst_hold");

      // Second instance: reset PC at the top of the address space.
      @(negedge clk);
      reset2 = 1'b0;
      @(negedge clk);
      check("wrap_req_addr", imem2_addr, 32'hFFFF_FFFC);
      @(negedge clk);
      @(negedge clk);
      check("wrap_inst", inst2_out, 32'hFFFF_FFFC);
      check("wrap_pc", pc2_out, 32'h0);
      check("wrap_valid", {31'd0, inst2_valid}, 32'd1);
      @(negedge clk);
      check("wrap_next_addr", imem2_addr, 32'h0);
      check("wrap_flush", {31'd0, if2_flush}, 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule : tb_if_fetch_stage

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues single-outstanding requests to instruction memory over a req/ready + rvalid handshake.
- Buffers one returned instruction and presents Inst/PC (PC = fetch address + 4) to IF/ID.
- Applies branch/jump redirects from ID, drops wrong-path responses and drives IF_Flush.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INST, 32'h0000_0000, instruction presented when no valid instruction is buffered

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
IF_ID_Write  in  1  IF/ID accepts this cycle (hazard unit; 0 = stall)
Branch_Taken  in  1  ID resolved taken branch
Branch_Target  in  32  branch target
Jump  in  1  ID jump
Jump_Target  in  32  jump target
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address; stable while imem_req=1 and imem_ready=0
imem_ready  in  1  request accepted when imem_req & imem_ready
imem_rvalid  in  1  response valid, at least 1 cycle after acceptance
imem_rdata  in  32  response instruction
Inst_out  out  32  to IF/ID Inst_in
PC_out  out  32  to IF/ID PC_in (instruction address + 4)
inst_valid  out  1  Inst_out/PC_out carry a real instruction
IF_Flush  out  1  to IF/ID flush

Behaviour:
- Interface:
  - One clock, clk.
  - reset is asynchronous and active-high. When asserted: state=IDLE, fetch_pc=RESET_PC, buffer empty, discard=0, pend_valid=0.
  - Reset values: imem_req=0, Inst_out=NOP_INST, PC_out=0, inst_valid=0, IF_Flush=0.
  - Instruction memory shares this reset, so no pre-reset response arrives. imem_rvalid is ignored outside WAIT.
- Registers:
  - fetch_pc drives imem_addr.
  - buf_inst, buf_pc, buf_valid.
  - discard flag.
  - pend_pc, pend_valid.
- Redirect:
  - redirect = Jump | Branch_Taken. Target = Jump ? Jump_Target : Branch_Target (Jump wins).
  - Target bits [1:0] are forced to 0.
  - IF_Flush = redirect, combinationally, same cycle.
  - Any redirect clears buf_valid at the next edge.
- Outputs:
  - Inst_out = buf_valid ? buf_inst : NOP_INST.
  - PC_out = buf_valid ? buf_pc+4 : 0.
  - inst_valid = buf_valid.
  - Consume = buf_valid & IF_ID_Write & !redirect.
- FSM (IDLE, REQ, WAIT, HOLD):
  - IDLE: imem_req=0. Next state REQ (one cycle after reset release). A redirect writes fetch_pc.
  - REQ: imem_req=1.
    - A redirect without acceptance stores pend_pc=target, pend_valid=1, and holds imem_addr.
    - On acceptance, go to WAIT and set discard = pend_valid | redirect. fetch_pc <= redirect ? target : pend_valid ? pend_pc : fetch_pc+4. Then clear pend_valid.
  - WAIT: a redirect sets discard=1 and fetch_pc=target.
    - On imem_rvalid with discard or redirect: drop the response, clear discard, go to REQ.
    - Otherwise: buf_inst=imem_rdata, buf_pc=fetch_pc-4 (the request address), buf_valid=1, go to HOLD.
  - HOLD: no request.
    - On consume: clear buf_valid, go to REQ.
    - On redirect: fetch_pc=target, go to REQ.
    - If IF_ID_Write=0: stay, outputs stable.
- Latency: with a 0-wait memory (ready same cycle, rvalid next cycle), an instruction appears 2 cycles after its request is raised. Throughput is one instruction per 3 cycles.
- Arithmetic: fetch_pc+4 and buf_pc+4 wrap modulo 2^32.
- Multiple redirects: the last redirect before the next acceptance wins.
- One request outstanding and one instruction buffered, maximum.
- Reset mid-operation: all state returns immediately (asynchronously) to the reset values above.

Decomposition:
- Shared package pipe_pkg holds:
  - the fetch_state_t enum (IDLE/REQ/WAIT/HOLD);
  - the NOP_INST default;
  - INST_W=32;
  - PC_INCR=4.
- No sub-module is natural. Buffer and pend logic stay inline.

Test Plan:
- Reset release, 0-wait memory, rdata 0x2002_0005 for address 0 -> imem_req rises at cycle 1, addr 0. Two cycles later Inst_out=0x2002_0005, PC_out=4, inst_valid=1. The next request is to address 4.
- IF_ID_Write=0 for 3 cycles with the buffer valid -> Inst_out/PC_out stable, imem_req=0. Drop IF_ID_Write back to 1 -> the next cycle requests address 8.
- Branch_Taken, Branch_Target=0x40, during WAIT for address 8 -> IF_Flush=1 that cycle. The address-8 response is dropped (inst_valid stays 0) and the next imem_addr=0x40.
- Redirect to 0x80 in REQ with imem_ready=0 for 2 cycles -> imem_addr holds the old value until accepted. Its response is dropped and the next request is 0x80.
- Jump=1 (0x103) with Branch_Taken=1 (0x80) -> next fetch address 0x100.
- RESET_PC=0xFFFF_FFFC -> first instruction has PC_out=0 and the next request is address 0. Assert reset mid-WAIT -> all outputs go to reset values immediately.
